// File: rtl/im_loader.sv
// Boot-time instruction-memory loader: takes a length-prefixed, XOR-checksummed
// byte stream, writes big-endian 32-bit words and stalls the CPU until verified.
module im_loader #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              cpu_hold
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CHK, S_DONE, S_ERROR
  } state_t;

  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  state_t            state_q;
  logic [7:0]        len_hi_q;
  logic [15:0]       len_q;
  logic [ADDR_W:0]   idx_q;
  logic [1:0]        cnt_q;
  logic [23:0]       asm_q;
  logic [7:0]        chk_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic              xfer;
  logic [15:0]       len_d;
  logic [31:0]       word_d;
  logic [ADDR_W:0]   idx_d;
  logic [7:0]        chk_d;
  logic              last_word;

  assign xfer      = byte_valid && byte_ready;
  assign len_d     = {len_hi_q, byte_data};
  assign word_d    = {asm_q, byte_data};
  assign idx_d     = idx_q + 1'b1;
  assign chk_d     = chk_q ^ asm_q[23:16] ^ asm_q[15:8] ^ asm_q[7:0] ^ byte_data;
  // Index is one bit wider than the address so N == 2**ADDR_W terminates cleanly.
  assign last_word = (16'(idx_d) == len_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      len_hi_q <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      asm_q    <= '0;
      chk_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state_q <= S_LEN_HI;
            idx_q   <= '0;
            chk_q   <= '0;
            cnt_q   <= '0;
          end
        end
        S_LEN_HI: begin
          if (xfer) begin
            len_hi_q <= byte_data;
            state_q  <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (xfer) begin
            len_q <= len_d;
            if ({1'b0, len_d} > DEPTH_L) state_q <= S_ERROR;
            else if (len_d == 16'd0)     state_q <= S_CHK;
            else                         state_q <= S_DATA;
          end
        end
        S_DATA: begin
          if (xfer) begin
            cnt_q <= cnt_q + 1'b1;
            asm_q <= word_d[23:0];
            if (cnt_q == 2'd3) begin
              we_q    <= 1'b1;
              addr_q  <= idx_q[ADDR_W-1:0];
              wdata_q <= word_d;
              idx_q   <= idx_d;
              chk_q   <= chk_d;
              if (last_word) state_q <= S_CHK;
            end
          end
        end
        S_CHK: begin
          if (xfer) state_q <= (byte_data == chk_q) ? S_DONE : S_ERROR;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign byte_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                      (state_q == S_DATA)   || (state_q == S_CHK);
  assign busy       = byte_ready;
  assign done       = (state_q == S_DONE);
  assign error      = (state_q == S_ERROR);
  assign cpu_hold   = (state_q != S_DONE);
  assign im_we      = we_q;
  assign im_addr    = addr_q;
  assign im_wdata   = wdata_q;

endmodule

// File: tb/tb_im_loader.sv
// Randomized bench for im_loader: streams built from a word-list model, writes and
// verdicts compared against that model.
`timescale 1ns/1ps
module tb_im_loader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready;
  logic        im_we;
  logic [9:0]  im_addr;
  logic [31:0] im_wdata;
  logic        busy, done, error, cpu_hold;

  im_loader #(.ADDR_W(10), .DEPTH(1024)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .busy(busy), .done(done), .error(error), .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model state
  logic [7:0]  stream_q[$];
  logic [31:0] src_words[$];
  logic [31:0] exp_words[$];
  bit          exp_done, exp_err;

  logic [9:0]  got_addr[$];
  logic [31:0] got_data[$];

  always @(negedge clk) begin
    if (im_we) begin
      got_addr.push_back(im_addr);
      got_data.push_back(im_wdata);
    end
  end

  // Build stream for N words (src_words first, then random); chk_ovr < 0 uses the true XOR.
  task automatic build(input int n, input int chk_ovr);
    logic [7:0]  x;
    logic [31:0] w;
    logic [15:0] n16;
    stream_q.delete();
    exp_words.delete();
    x = 8'h00;
    n16 = n[15:0];
    stream_q.push_back(n16[15:8]);
    stream_q.push_back(n16[7:0]);
    if (n > 1024) begin
      exp_err = 1'b1;
      exp_done = 1'b0;
    end else begin
      for (int k = 0; k < n; k++) begin
        w = (src_words.size() > 0) ? src_words.pop_front() : $urandom;
        exp_words.push_back(w);
        for (int b = 3; b >= 0; b--) begin
          stream_q.push_back(w[b*8 +: 8]);
          x ^= w[b*8 +: 8];
        end
      end
      if (chk_ovr >= 0) begin
        stream_q.push_back(chk_ovr[7:0]);
        exp_done = (chk_ovr[7:0] == x);
      end else begin
        stream_q.push_back(x);
        exp_done = 1'b1;
      end
      exp_err = !exp_done;
    end
    src_words.delete();
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_ready", byte_ready, 1);
  endtask

  // Feeds the first `limit` bytes of stream_q; returns on the negedge after the last transfer.
  task automatic feed(input int stall_pct, input bit mid_start, input int limit, output int drops);
    int i = 0;
    int cyc = 0;
    bit started = 0;
    int budget = limit * 5 + 100;
    drops = 0;
    while (i < limit && cyc < budget) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (mid_start && !started && i == 6) begin
        start = 1'b1;
        started = 1;
      end
      if (!byte_ready) drops++;
      byte_valid = (stall_pct == 0) || ($urandom_range(99) >= stall_pct);
      byte_data = stream_q[i];
      if (byte_valid && byte_ready) i++;
    end
    check("feed_bytes_accepted", i, limit);
    @(negedge clk);
    byte_valid = 1'b0;
    byte_data = 8'h00;
    start = 1'b0;
  endtask

  task automatic run_load(input string name, input int stall_pct, input bit mid_start);
    int drops;
    got_addr.delete();
    got_data.delete();
    do_start();
    feed(stall_pct, mid_start, stream_q.size(), drops);
    check({name, "_ready_drops"}, drops, 0);
    check({name, "_done"}, done, exp_done);
    check({name, "_error"}, error, exp_err);
    check({name, "_busy"}, busy, 0);
    check({name, "_cpu_hold"}, cpu_hold, !exp_done);
    check({name, "_nwrites"}, got_addr.size(), exp_words.size());
    for (int k = 0; k < exp_words.size() && k < got_addr.size(); k++) begin
      check({name, "_addr"}, got_addr[k], k % 1024);
      check({name, "_data"}, got_data[k], exp_words[k]);
    end
    repeat (3) @(negedge clk);
    check({name, "_done_sticky"}, done, exp_done);
    check({name, "_error_sticky"}, error, exp_err);
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_ready"}, byte_ready, 0);
    check({name, "_we"}, im_we, 0);
    check({name, "_addr"}, im_addr, 0);
    check({name, "_wdata"}, im_wdata, 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_done"}, done, 0);
    check({name, "_error"}, error, 0);
    check({name, "_cpu_hold"}, cpu_hold, 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int drops;
    logic [7:0] bad;

    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals("idle");

    src_words.push_back(32'h12345678);
    src_words.push_back(32'h9ABCDEF0);
    build(2, -1);
    run_load("basic", 0, 0);

    src_words.push_back(32'h12345678);
    src_words.push_back(32'h9ABCDEF0);
    build(2, 8'h89);
    run_load("badchk", 0, 0);

    build(16'h0401, -1);
    run_load("len_over", 0, 0);

    build(0, 8'h00);
    run_load("len_zero", 0, 0);

    build(1024, -1);
    run_load("full_depth", 0, 0);

    for (int t = 0; t < 6; t++) begin
      n = $urandom_range(3, 24);
      bad = (t % 3 == 2) ? 8'($urandom_range(1, 255)) : 8'h00;
      for (int k = 0; k < n; k++) src_words.push_back($urandom);
      build(n, -1);
      if (bad != 8'h00) begin
        stream_q[stream_q.size() - 1] ^= bad;
        exp_done = 1'b0;
        exp_err = 1'b1;
      end
      run_load("rand_stall", 40, 1);
      run_load("rand_nostall", 0, 0);
    end

    build(3, -1);
    got_addr.delete();
    got_data.delete();
    do_start();
    feed(0, 0, 8, drops);
    #2 reset_n = 1'b0;
    #1 check_reset_vals("async_reset");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("after_reset_busy", busy, 0);
    build(3, -1);
    run_load("reload", 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
